block_data_dispatcher: RTL and testbench
========================================

# block_data_dispatcher

Consumes the 320-bit line assembled by `memory_controller` and distributes it to two places: one write into the cache data/tag array (array updater) and the single missed 32-bit word returned to the fetch-side user (user readout). Sits directly downstream of `memory_controller` on `o_mem_block_data`/`o_mem_block_data_valid`, and alongside the miss handler, which supplies the missing address.

## Interface

Parameters:
- `ADDR_WIDTH`, 16: block address width.
- `WORD_WIDTH`, 32: user word width.
- `WORDS_PER_BLOCK`, 10: words per line.
- `BLOCK_WIDTH`, 320: `WORDS_PER_BLOCK*WORD_WIDTH`.
- `INDEX_WIDTH`, 4: set index bits (16 sets).
- `TAG_WIDTH`, 12: `ADDR_WIDTH-INDEX_WIDTH`.

Ports:
- Clocking and reset (already decided): one clock, `clk`; reset `arst_n` is asynchronous and active-low.
- `clk`  in  1  clock.
- `arst_n`  in  1  asynchronous active-low reset.
- `i_halt`  in  1  global stall; freezes all state.
- `i_miss_block_addr`  in  16  block address of the pending miss.
- `i_miss_word_offset`  in  4  word within the block.
- `i_miss_valid`  in  1  miss request valid.
- `o_miss_ready`  out  1  dispatcher can accept a miss.
- `i_mem_block_data`  in  320  line from `memory_controller`.
- `i_mem_block_data_valid`  in  1  line valid; sticky level, not a pulse.
- `o_arr_wr_en`  out  1  one-cycle array write strobe.
- `o_arr_wr_index`  out  4  `block_addr[3:0]`.
- `o_arr_wr_tag`  out  12  `block_addr[15:4]`.
- `o_arr_wr_data`  out  320  captured line.
- `o_user_data`  out  32  missed word.
- `o_user_data_valid`  out  1  word valid.
- `o_user_err`  out  1  offset was ≥ 10; qualified by `o_user_data_valid`.
- `i_user_ready`  in  1  user accepts word.

## Operation

- **Miss capture.** When `i_miss_valid & o_miss_ready`, latch address and offset and set `pending` = 1.
  - `o_miss_ready = (state==IDLE) & ~pending & ~i_halt`.
- **Line detection.** Register `r_blk_valid_d`. A line arrives when `i_mem_block_data_valid & ~r_blk_valid_d`, i.e. on the rising edge only. The sticky high level must never cause a second write.
- **FSM states:** IDLE, WRITE, RESPOND.
  - IDLE → WRITE on a line arrival. Capture `i_mem_block_data` into the line register in the same edge.
  - WRITE → RESPOND if `pending`, otherwise → IDLE.
  - RESPOND → IDLE on `i_user_ready`. Clear `pending` on the same edge.
- **Array write.** `o_arr_wr_en = (state==WRITE) & ~i_halt`.
  - Index and tag come from the latched miss address.
  - A line arriving with no pending miss is written with index/tag = 0 and produces no user response. Verification flags this as a protocol error on a monitor.
- **Word select.** `o_user_data` = line word `offset`, i.e. bits `[32*offset+31 : 32*offset]`, implemented as an explicit case with no multiplier.
  - Offset ≥ 10 gives `o_user_data` = 0 and `o_user_err` = 1.
- **Halt.** While `i_halt` = 1 every register holds.
  - `o_arr_wr_en` is forced to 0; the write reissues after release.
  - `o_user_data_valid` is held at its pre-halt value.
  - `i_user_ready` is ignored.
- **Reset.** Async clear of all registers. State = IDLE, `pending` = 0, `r_blk_valid_d` = 0, line register = 0, latched address/offset = 0.
  - Reset values of outputs: `o_arr_wr_en` 0, `o_arr_wr_index` 0, `o_arr_wr_tag` 0, `o_arr_wr_data` 0, `o_user_data` 0, `o_user_data_valid` 0, `o_user_err` 0.
  - `o_miss_ready` is 1 after reset when `i_halt` = 0.
  - Reset mid-operation discards the line and the pending miss.

## Timing

- Line rising edge sampled at edge N.
- `o_arr_wr_en` = 1 during cycle N+1 only.
- `o_user_data_valid` = 1 from cycle N+2 until the edge where `i_user_ready` = 1.
  - Latency from line to word is 2 cycles.
  - `o_user_data` is stable while valid.
- Valid/ready handshake: the dispatcher never drops valid without ready. Ready may be asserted before valid; the transfer occurs on the first edge with both high.
- Next miss is accepted no earlier than the cycle after the RESPOND → IDLE transition.
- A line arriving while in WRITE or RESPOND is a rising edge missed by design. `memory_controller` cannot produce one because the miss handler blocks a new request, and the monitor asserts on it.

## Structure

- Shared package `icache_pkg` holds:
  - `ADDR_WIDTH`, `WORD_WIDTH`, `WORDS_PER_BLOCK`, `BLOCK_WIDTH`, `INDEX_WIDTH`, `TAG_WIDTH`;
  - the dispatcher state encodings `DISP_IDLE`, `DISP_WRITE`, `DISP_RESPOND`.
- One sub-module, `block_word_select`: combinational 10:1 word mux plus out-of-range flag. Everything else stays in the top.

## Test plan

1. **Basic miss.** Reset, then miss addr 0x1234, offset 3. Line with word k = 0xA0000000+k rises at N. Required:
   - `o_arr_wr_en` at N+1 with index 0x4, tag 0x123;
   - `o_user_data` = 0xA0000003 valid from N+2;
   - `i_user_ready` at N+4 drops valid at N+5.
2. **Sticky valid.** Hold `i_mem_block_data_valid` high for 20 cycles after scenario 1 → exactly one `o_arr_wr_en` pulse.
3. **Halt.** Assert `i_halt` during WRITE for 3 cycles:
   - `o_arr_wr_en` = 0 throughout the halt;
   - a single pulse on the first cycle after release;
   - the user word follows 1 cycle later.
4. **Offset boundary.**
   - Offset 9 → upper word `[319:288]` returned.
   - Offset 12 → `o_user_data` = 0, `o_user_err` = 1, array still written.
5. **Backpressure/ready.**
   - `o_miss_ready` = 0 from miss accept until the handshake completes.
   - A second miss presented during RESPOND is accepted only after the IDLE return.
6. **Reset mid-operation.** Assert `arst_n` = 0 in RESPOND → all outputs 0 immediately, `o_miss_ready` = 1 after release.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared instruction-cache definitions: geometry constants and the state
// encoding of the block data dispatcher.
package icache_pkg;

  localparam int ADDR_WIDTH      = 16;
  localparam int WORD_WIDTH      = 32;
  localparam int WORDS_PER_BLOCK = 10;
  localparam int BLOCK_WIDTH     = WORDS_PER_BLOCK * WORD_WIDTH;
  localparam int INDEX_WIDTH     = 4;
  localparam int TAG_WIDTH       = ADDR_WIDTH - INDEX_WIDTH;
  localparam int OFFSET_WIDTH    = 4;

  typedef enum logic [1:0] {
    DISP_IDLE    = 2'd0,
    DISP_WRITE   = 2'd1,
    DISP_RESPOND = 2'd2
  } disp_state_e;

endpackage : icache_pkg

// File: rtl/block_word_select.sv
// Combinational 10:1 word mux over a cache line, with an out-of-range flag
// for offsets beyond the last word of the line.
module block_word_select
  import icache_pkg::*;
(
  input  logic [BLOCK_WIDTH-1:0]  line,
  input  logic [OFFSET_WIDTH-1:0] offset,
  output logic [WORD_WIDTH-1:0]   word,
  output logic                    err
);

  // Pick the addressed word; offsets 10..15 return zero and raise err.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    word = '0;
    err  = 1'b0;
    case (offset)
      4'd0:    word = line[31:0];
      4'd1:    word = line[63:32];
      4'd2:    word = line[95:64];
      4'd3:    word = line[127:96];
      4'd4:    word = line[159:128];
      4'd5:    word = line[191:160];
      4'd6:    word = line[223:192];
      4'd7:    word = line[255:224];
      4'd8:    word = line[287:256];
      4'd9:    word = line[319:288];
      default: err  = 1'b1;
    endcase
  end

endmodule : block_word_select

// File: rtl/block_data_dispatcher.sv
// Takes the line assembled by the memory controller and hands it out twice:
// one write strobe into the cache data/tag array, and the single missed word
// back to the fetch-side user through a valid/ready handshake.
module block_data_dispatcher
  import icache_pkg::*;
(
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    i_halt,
  input  logic [ADDR_WIDTH-1:0]   i_miss_block_addr,
  input  logic [OFFSET_WIDTH-1:0] i_miss_word_offset,
  input  logic                    i_miss_valid,
  output logic                    o_miss_ready,
  input  logic [BLOCK_WIDTH-1:0]  i_mem_block_data,
  input  logic                    i_mem_block_data_valid,
  output logic                    o_arr_wr_en,
  output logic [INDEX_WIDTH-1:0]  o_arr_wr_index,
  output logic [TAG_WIDTH-1:0]    o_arr_wr_tag,
  output logic [BLOCK_WIDTH-1:0]  o_arr_wr_data,
  output logic [WORD_WIDTH-1:0]   o_user_data,
  output logic                    o_user_data_valid,
  output logic                    o_user_err,
  input  logic                    i_user_ready
);

  disp_state_e             state_q;
  disp_state_e             state_d;
  logic                    pending_q;
  logic                    r_blk_valid_d;
  logic [BLOCK_WIDTH-1:0]  line_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [OFFSET_WIDTH-1:0] offset_q;

  logic line_rise;
  logic line_capture;
  logic wr_active;
  logic respond_done;
  logic miss_accept;

  // The line valid from the controller is a sticky level; only its rising
  // edge marks a new line.
  assign line_rise   = i_mem_block_data_valid & ~r_blk_valid_d;

  assign o_miss_ready = (state_q == DISP_IDLE) & ~pending_q & ~i_halt;
  assign miss_accept  = i_miss_valid & o_miss_ready;

  // Next-state and per-state strobes; halt gating is applied at the registers.
  always_comb begin
    state_d      = state_q;
    line_capture = 1'b0;
    wr_active    = 1'b0;
    respond_done = 1'b0;
    case (state_q)
      DISP_IDLE: begin
        if (line_rise) begin
          state_d      = DISP_WRITE;
          line_capture = 1'b1;
        end
      end
      DISP_WRITE: begin
        wr_active = 1'b1;
        state_d   = pending_q ? DISP_RESPOND : DISP_IDLE;
      end
      DISP_RESPOND: begin
        if (i_user_ready) begin
          state_d      = DISP_IDLE;
          respond_done = 1'b1;
        end
      end
      default: state_d = DISP_IDLE;
    endcase
  end

  // State, edge detector, miss latch and line register; all hold under halt.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q       <= DISP_IDLE;
      pending_q     <= 1'b0;
      r_blk_valid_d <= 1'b0;
      // NOTE: the 320-bit line register is reset deliberately so the array
      // data and user word outputs read zero during and after reset.
      line_q        <= '0;
      addr_q        <= '0;
      offset_q      <= '0;
    end else if (!i_halt) begin
      // NOTE: non-blocking assignments keep every register reading the
      // pre-edge values of the others, independent of statement order.
      state_q       <= state_d;
      r_blk_valid_d <= i_mem_block_data_valid;
      if (line_capture) line_q <= i_mem_block_data;
      if (miss_accept) begin
        pending_q <= 1'b1;
        addr_q    <= i_miss_block_addr;
        offset_q  <= i_miss_word_offset;
      end else if (respond_done) begin
        pending_q <= 1'b0;
      end
    end
  end

  // A line that arrives with no miss outstanding is written to set 0, tag 0.
  assign o_arr_wr_en       = wr_active & ~i_halt;
  assign o_arr_wr_index    = pending_q ? addr_q[INDEX_WIDTH-1:0] : '0;
  assign o_arr_wr_tag      = pending_q ? addr_q[ADDR_WIDTH-1:INDEX_WIDTH] : '0;
  assign o_arr_wr_data     = line_q;
  assign o_user_data_valid = (state_q == DISP_RESPOND);

  block_word_select u_word_select (
    .line   (line_q),
    .offset (offset_q),
    .word   (o_user_data),
    .err    (o_user_err)
  );

endmodule : block_data_dispatcher

// File: tb/tb_block_data_dispatcher.sv
// Self-checking bench for block_data_dispatcher: directed scenarios plus
// randomized misses checked against a transaction-level reference model.
module tb_block_data_dispatcher;
  import icache_pkg::*;

  logic         clk = 1'b0;
  logic         arst_n;
  logic         i_halt;
  logic [15:0]  i_miss_block_addr;
  logic [3:0]   i_miss_word_offset;
  logic         i_miss_valid;
  logic         o_miss_ready;
  logic [319:0] i_mem_block_data;
  logic         i_mem_block_data_valid;
  logic         o_arr_wr_en;
  logic [3:0]   o_arr_wr_index;
  logic [11:0]  o_arr_wr_tag;
  logic [319:0] o_arr_wr_data;
  logic [31:0]  o_user_data;
  logic         o_user_data_valid;
  logic         o_user_err;
  logic         i_user_ready;

  int vectors     = 0;
  int miscompares = 0;
  int wr_count    = 0;

  block_data_dispatcher dut (
    .clk                    (clk),
    .arst_n                 (arst_n),
    .i_halt                 (i_halt),
    .i_miss_block_addr      (i_miss_block_addr),
    .i_miss_word_offset     (i_miss_word_offset),
    .i_miss_valid           (i_miss_valid),
    .o_miss_ready           (o_miss_ready),
    .i_mem_block_data       (i_mem_block_data),
    .i_mem_block_data_valid (i_mem_block_data_valid),
    .o_arr_wr_en            (o_arr_wr_en),
    .o_arr_wr_index         (o_arr_wr_index),
    .o_arr_wr_tag           (o_arr_wr_tag),
    .o_arr_wr_data          (o_arr_wr_data),
    .o_user_data            (o_user_data),
    .o_user_data_valid      (o_user_data_valid),
    .o_user_err             (o_user_err),
    .i_user_ready           (i_user_ready)
  );

  always #5 clk = ~clk;

  // Count array write strobes seen at mid-cycle.
  always @(negedge clk) if (o_arr_wr_en === 1'b1) wr_count++;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: the user word is word 'off' of the line, or 0 past word 9.
  function automatic logic [31:0] ref_word(input logic [319:0] l, input int off);
    if (off > 9) return 32'h0;
    return l[off*32 +: 32];
  endfunction

  function automatic logic [319:0] rand_line();
    logic [319:0] l;
    for (int i = 0; i < 10; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [319:0] ramp_line(input logic [31:0] base);
    logic [319:0] l;
    for (int i = 0; i < 10; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete miss: request, line arrival, array write, user handshake.
  task automatic run_txn(input string name, input logic [15:0] addr, input logic [3:0] off,
                         input logic [319:0] line, input int halt_cyc, input int ready_wait,
                         input bit early_ready, input bit keep_line);
    logic [31:0] exp_word;
    logic        exp_err;
    exp_word = ref_word(line, int'(off));
    exp_err  = (off > 4'd9);

    step();
    i_miss_valid       = 1'b1;
    i_miss_block_addr  = addr;
    i_miss_word_offset = off;
    @(negedge clk);
    vectors++;
    if (o_miss_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s miss_ready_idle: got %b want 1", name, o_miss_ready);
    end

    step();
    i_miss_valid           = 1'b0;
    i_mem_block_data       = line;
    i_mem_block_data_valid = 1'b1;
    if (early_ready) i_user_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if ({o_miss_ready, o_arr_wr_en, o_user_data_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL %s pending_wait: got ready/wr/valid=%b want 000", name,
               {o_miss_ready, o_arr_wr_en, o_user_data_valid});
    end

    step();  // line rise sampled on this edge
    if (halt_cyc > 0) begin
      i_halt = 1'b1;
      for (int i = 0; i < halt_cyc; i++) begin
        @(negedge clk);
        vectors++;
        if ({o_arr_wr_en, o_user_data_valid, o_miss_ready} !== 3'b000) begin
          miscompares++;
          $display("FAIL %s halt_hold: got wr/valid/ready=%b want 000", name,
                   {o_arr_wr_en, o_user_data_valid, o_miss_ready});
        end
        step();
      end
      i_halt = 1'b0;
    end
    @(negedge clk);
    vectors++;
    if ({o_arr_wr_en, o_user_data_valid, o_arr_wr_index, o_arr_wr_tag} !==
        {1'b1, 1'b0, addr[3:0], addr[15:4]}) begin
      miscompares++;
      $display("FAIL %s array_write: got en=%b valid=%b idx=%h tag=%h want en=1 valid=0 idx=%h tag=%h",
               name, o_arr_wr_en, o_user_data_valid, o_arr_wr_index, o_arr_wr_tag, addr[3:0], addr[15:4]);
    end
    vectors++;
    if (o_arr_wr_data !== line) begin
      miscompares++;
      $display("FAIL %s array_data: got %h want %h", name, o_arr_wr_data[63:0], line[63:0]);
    end

    step();
    if (!keep_line) i_mem_block_data_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({o_arr_wr_en, o_user_data_valid, o_miss_ready, o_user_err, o_user_data} !==
        {1'b0, 1'b1, 1'b0, exp_err, exp_word}) begin
      miscompares++;
      $display("FAIL %s user_word: got wr=%b valid=%b rdy=%b err=%b data=%h want wr=0 valid=1 rdy=0 err=%b data=%h",
               name, o_arr_wr_en, o_user_data_valid, o_miss_ready, o_user_err, o_user_data, exp_err, exp_word);
    end

    if (!early_ready) begin
      for (int i = 0; i < ready_wait; i++) begin
        step();
        @(negedge clk);
        vectors++;
        if ({o_user_data_valid, o_user_data} !== {1'b1, exp_word}) begin
          miscompares++;
          $display("FAIL %s hold_valid: got valid=%b data=%h want valid=1 data=%h",
                   name, o_user_data_valid, o_user_data, exp_word);
        end
      end
      step();
      i_user_ready = 1'b1;
    end
    step();  // handshake edge
    i_user_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if ({o_user_data_valid, o_miss_ready, o_arr_wr_en} !== 3'b010) begin
      miscompares++;
      $display("FAIL %s after_handshake: got valid/ready/wr=%b want 010", name,
               {o_user_data_valid, o_miss_ready, o_arr_wr_en});
    end
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    i_halt = 1'b0; i_miss_block_addr = '0; i_miss_word_offset = '0; i_miss_valid = 1'b0;
    i_mem_block_data = '0; i_mem_block_data_valid = 1'b0; i_user_ready = 1'b0;
    #12;
    vectors++;
    if ({o_arr_wr_en, o_arr_wr_index, o_arr_wr_tag, o_user_data, o_user_data_valid, o_user_err} !== '0 ||
        o_arr_wr_data !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got wr=%b idx=%h tag=%h data=%h valid=%b err=%b want all 0",
               o_arr_wr_en, o_arr_wr_index, o_arr_wr_tag, o_user_data, o_user_data_valid, o_user_err);
    end
    i_halt = 1'b1;
    #1;
    vectors++;
    if (o_miss_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready_halted: got %b want 0", o_miss_ready);
    end
    i_halt = 1'b0;
    #1;
    vectors++;
    if (o_miss_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 1", o_miss_ready);
    end
    step();
    arst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_and_sticky();
    int base;
    base = wr_count;
    run_txn("basic", 16'h1234, 4'd3, ramp_line(32'hA000_0000), 0, 1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step();
    vectors++;
    if (wr_count - base !== 1) begin
      miscompares++;
      $display("FAIL sticky_single_write: got %0d pulses want 1", wr_count - base);
    end
    i_mem_block_data_valid = 1'b0;
    step();
  endtask

  task automatic test_halt();
    int base;
    base = wr_count;
    run_txn("halt", 16'hBEEF, 4'd5, rand_line(), 3, 0, 1'b0, 1'b0);
    step();
    vectors++;
    if (wr_count - base !== 1) begin
      miscompares++;
      $display("FAIL halt_single_write: got %0d pulses want 1", wr_count - base);
    end
  endtask

  task automatic test_offset_boundary();
    run_txn("offset9", 16'h0F0A, 4'd9, rand_line(), 0, 0, 1'b0, 1'b0);
    run_txn("offset12", 16'h7651, 4'd12, rand_line(), 0, 0, 1'b0, 1'b0);
    run_txn("offset0", 16'h0001, 4'd0, rand_line(), 0, 2, 1'b0, 1'b0);
  endtask

  task automatic test_no_pending();
    logic [319:0] line;
    line = rand_line();
    step();
    i_mem_block_data = line;
    i_mem_block_data_valid = 1'b1;
    step();
    @(negedge clk);
    vectors++;
    if ({o_arr_wr_en, o_arr_wr_index, o_arr_wr_tag} !== {1'b1, 4'h0, 12'h000} || o_arr_wr_data !== line) begin
      miscompares++;
      $display("FAIL orphan_write: got en=%b idx=%h tag=%h want en=1 idx=0 tag=0",
               o_arr_wr_en, o_arr_wr_index, o_arr_wr_tag);
    end
    step();
    i_mem_block_data_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({o_arr_wr_en, o_user_data_valid, o_miss_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL orphan_no_response: got wr/valid/ready=%b want 001",
               {o_arr_wr_en, o_user_data_valid, o_miss_ready});
    end
  endtask

  task automatic test_back_to_back();
    logic [319:0] l1, l2;
    l1 = rand_line();
    l2 = rand_line();
    step();
    i_miss_valid = 1'b1; i_miss_block_addr = 16'h4321; i_miss_word_offset = 4'd7;
    step();
    i_miss_valid = 1'b0;
    i_mem_block_data = l1; i_mem_block_data_valid = 1'b1;
    step();
    step();
    i_mem_block_data_valid = 1'b0;
    // Now in RESPOND: present the second miss and keep it waiting.
    i_miss_valid = 1'b1; i_miss_block_addr = 16'h9876; i_miss_word_offset = 4'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({o_user_data_valid, o_miss_ready, o_user_data} !== {1'b1, 1'b0, ref_word(l1, 7)}) begin
        miscompares++;
        $display("FAIL b2b_blocked: got valid=%b ready=%b data=%h want valid=1 ready=0 data=%h",
                 o_user_data_valid, o_miss_ready, o_user_data, ref_word(l1, 7));
      end
      step();
    end
    i_user_ready = 1'b1;
    step();  // handshake edge, back to IDLE
    i_user_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if ({o_user_data_valid, o_miss_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL b2b_idle_accept: got valid/ready=%b want 01", {o_user_data_valid, o_miss_ready});
    end
    step();  // second miss accepted here
    i_miss_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (o_miss_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_pending: got ready=%b want 0", o_miss_ready);
    end
    step();
    i_mem_block_data = l2; i_mem_block_data_valid = 1'b1;
    step();
    @(negedge clk);
    vectors++;
    if ({o_arr_wr_en, o_arr_wr_index, o_arr_wr_tag} !== {1'b1, 4'h6, 12'h987}) begin
      miscompares++;
      $display("FAIL b2b_write2: got en=%b idx=%h tag=%h want en=1 idx=6 tag=987",
               o_arr_wr_en, o_arr_wr_index, o_arr_wr_tag);
    end
    step();
    i_mem_block_data_valid = 1'b0;
    i_user_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if ({o_user_data_valid, o_user_data} !== {1'b1, ref_word(l2, 2)}) begin
      miscompares++;
      $display("FAIL b2b_word2: got valid=%b data=%h want valid=1 data=%h",
               o_user_data_valid, o_user_data, ref_word(l2, 2));
    end
    step();
    i_user_ready = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    step();
    i_miss_valid = 1'b1; i_miss_block_addr = 16'hFFFF; i_miss_word_offset = 4'd4;
    step();
    i_miss_valid = 1'b0;
    i_mem_block_data = ramp_line(32'h5555_0000); i_mem_block_data_valid = 1'b1;
    step();
    step();
    @(negedge clk);
    vectors++;
    if ({o_user_data_valid, o_user_data} !== {1'b1, 32'h5555_0004}) begin
      miscompares++;
      $display("FAIL midreset_pre: got valid=%b data=%h want valid=1 data=55550004",
               o_user_data_valid, o_user_data);
    end
    arst_n = 1'b0;
    i_mem_block_data_valid = 1'b0;
    #1;
    vectors++;
    if ({o_arr_wr_en, o_arr_wr_index, o_arr_wr_tag, o_user_data, o_user_data_valid, o_user_err} !== '0 ||
        o_arr_wr_data !== '0) begin
      miscompares++;
      $display("FAIL midreset_clear: got wr=%b idx=%h tag=%h data=%h valid=%b err=%b want all 0",
               o_arr_wr_en, o_arr_wr_index, o_arr_wr_tag, o_user_data, o_user_data_valid, o_user_err);
    end
    step();
    arst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({o_miss_ready, o_user_data_valid, o_arr_wr_en} !== 3'b100) begin
      miscompares++;
      $display("FAIL midreset_release: got ready/valid/wr=%b want 100",
               {o_miss_ready, o_user_data_valid, o_arr_wr_en});
    end
    run_txn("post_reset", 16'h2468, 4'd1, rand_line(), 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      run_txn("random", 16'($urandom), 4'($urandom_range(0, 15)), rand_line(),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic_and_sticky();
    test_halt();
    test_offset_boundary();
    test_no_pending();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_block_data_dispatcher
